// File: rtl/adder_buf_pkg.sv
// Shared sizing for the two-stage pipelined adder.
package adder_buf_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  // Low half is added in stage 1, the remaining high half in stage 2.
  function automatic int unsigned lo_width(input int unsigned width);
    return width / 2;
  endfunction

  function automatic int unsigned hi_width(input int unsigned width);
    return width - (width / 2);
  endfunction

endpackage

// File: rtl/adder_buf_slice.sv
// Combinational N-bit adder slice with carry-in and carry-out.
module adder_buf_slice #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum_c,
  output logic         cout_c
);

  localparam int unsigned NW = N + 1;

  logic [N:0] full;

  assign full   = NW'(a) + NW'(b) + NW'(cin);
  assign sum_c  = full[N-1:0];
  assign cout_c = full[N];

endmodule

// File: rtl/adder_buf.sv
// Two-stage pipelined unsigned adder: low half in stage 1, high half plus carry in stage 2.
module adder_buf
  import adder_buf_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH:0]   out_sum
);

  localparam int unsigned LO_W = lo_width(WIDTH);
  localparam int unsigned HI_W = hi_width(WIDTH);

  logic [LO_W-1:0] lo_sum_c;
  logic            lo_cout_c;
  logic [HI_W-1:0] hi_sum_c;
  logic            hi_cout_c;

  logic [LO_W-1:0] s1_lo;
  logic            s1_c;
  logic [HI_W-1:0] s1_ah;
  logic [HI_W-1:0] s1_bh;

  adder_buf_slice #(.N(LO_W)) u_lo (
    .a      (in_a[LO_W-1:0]),
    .b      (in_b[LO_W-1:0]),
    .cin    (1'b0),
    .sum_c  (lo_sum_c),
    .cout_c (lo_cout_c)
  );

  adder_buf_slice #(.N(HI_W)) u_hi (
    .a      (s1_ah),
    .b      (s1_bh),
    .cin    (s1_c),
    .sum_c  (hi_sum_c),
    .cout_c (hi_cout_c)
  );

  // Stage 1: register low partial sum, its carry and the high operands.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_lo <= '0;
      s1_c  <= 1'b0;
      s1_ah <= '0;
      s1_bh <= '0;
    end else begin
      s1_lo <= lo_sum_c;
      s1_c  <= lo_cout_c;
      s1_ah <= in_a[WIDTH-1:LO_W];
      s1_bh <= in_b[WIDTH-1:LO_W];
    end
  end

  // Stage 2: combine high-half result with the delayed low half.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_sum <= '0;
    end else begin
      out_sum <= {hi_cout_c, hi_sum_c, s1_lo};
    end
  end

endmodule

// File: tb/tb_adder_buf.sv
// Self-checking bench for adder_buf: vector table, reset corners and random stream.
module tb_adder_buf;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   exp;
  } vec_t;

  logic         clock;
  logic         reset;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W:0]   out_sum;

  int checks;
  int errors;
  bit fresh;
  logic [W:0] sb[$];
  vec_t vecs[8];

  adder_buf #(.WIDTH(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .in_a    (in_a),
    .in_b    (in_b),
    .out_sum (out_sum)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%05h expected 0x%05h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one operand pair at the falling edge, then compare after the rising edge.
  task automatic cycle(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] exp, input bit rel, input string name);
    logic [W:0] e;
    @(negedge clock);
    if (rel) reset = 1'b1;
    in_a = a;
    in_b = b;
    sb.push_back(exp);
    @(posedge clock);
    #1;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check(name, out_sum, e);
    end else if (fresh) begin
      check("prime_zero", out_sum, '0);
    end
    fresh = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks = 0;
    errors = 0;
    fresh  = 1'b0;
    reset  = 1'b0;
    in_a   = 16'd199;
    in_b   = 16'd1;

    vecs[0] = '{16'd199,  16'd1,   17'd200};
    vecs[1] = '{16'd199,  16'd100, 17'd299};
    vecs[2] = '{16'd1990, 16'd183, 17'd2173};
    vecs[3] = '{16'h00FF, 16'h0001, 17'h00100};
    vecs[4] = '{16'h80FF, 16'h7F01, 17'h10000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 17'h1FFFE};
    vecs[6] = '{16'hFFFF, 16'h0001, 17'h10000};
    vecs[7] = '{16'h0000, 16'h0000, 17'h00000};

    // Held reset: nothing captured, output stays zero.
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check("reset_hold", out_sum, '0);
    end

    sb.delete();
    fresh = 1'b1;
    cycle(16'd199, 16'd1, 17'd200, 1'b1, "first_after_reset");
    cycle(16'd199, 16'd1, 17'd200, 1'b0, "first_after_reset");

    for (int i = 0; i < 8; i++)
      cycle(vecs[i].a, vecs[i].b, vecs[i].exp, 1'b0, "table");
    cycle(16'd0, 16'd0, 17'd0, 1'b0, "table_flush");

    // Mid-stream reset clears the output without a clock edge.
    cycle(16'd1000, 16'd2000, 17'd3000, 1'b0, "pre_reset");
    cycle(16'd4000, 16'd5000, 17'd9000, 1'b0, "pre_reset");
    #2;
    reset = 1'b0;
    #1;
    check("async_clear", out_sum, '0);
    @(posedge clock);
    #1;
    check("reset_mid_hold", out_sum, '0);
    sb.delete();
    fresh = 1'b1;
    cycle(16'd7, 16'd8, 17'd15, 1'b1, "post_reset");
    cycle(16'h1234, 16'h4321, 17'h05555, 1'b0, "post_reset");
    cycle(16'hF0F0, 16'h0F10, 17'h10000, 1'b0, "post_reset");

    // Full-rate random stream against an independent 17-bit sum.
    for (int i = 0; i < 1000; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      cycle(ra, rb, {1'b0, ra} + {1'b0, rb}, 1'b0, "random");
    end
    cycle(16'd0, 16'd0, 17'd0, 1'b0, "random_flush");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/adder_buf.md
Name: adder_buf

Overview:
- Two-stage pipelined unsigned adder: two WIDTH-bit operands in, registered WIDTH+1-bit sum out.
- Stage 1 adds the low half and registers the partial sum, the carry and the high-half operands.
- Stage 2 adds the high halves plus the carry and registers the full sum.
- Used as a throughput-1 arithmetic buffer in datapaths that tolerate a fixed two-cycle latency.

Parameters:
- WIDTH, 16, operand width in bits; must be even and >= 2.
- LO_W, WIDTH/2, width of the low-half slice added in stage 1. Derived; not overridden independently.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset; clears all pipeline state while low.
- in_a  input  WIDTH  operand A, unsigned.
- in_b  input  WIDTH  operand B, unsigned.
- out_sum  output  WIDTH+1  registered unsigned sum in_a+in_b; MSB is the carry-out.

Behaviour:
- Reset:
  - reset low asynchronously clears every pipeline register: stage-1 low sum, stage-1 carry, stage-1 high operands, and out_sum.
  - out_sum = 0 while reset is low and until the first valid result emerges.
  - Deassertion is sampled normally at the next rising edge.
  - No input is captured on an edge where reset is low.
- Stage 1 (rising edge k):
  - s1_lo <= in_a[LO_W-1:0] + in_b[LO_W-1:0], LO_W bits.
  - s1_c <= carry-out of that addition.
  - s1_ah <= in_a[WIDTH-1:LO_W]; s1_bh <= in_b[WIDTH-1:LO_W].
- Stage 2 (rising edge k+1):
  - out_sum <= {s1_ah + s1_bh + s1_c (WIDTH-LO_W+1 bits), s1_lo}.
- Latency: operands sampled at edge k appear on out_sum after edge k+1, i.e. 2 cycles.
- Throughput: one new operand pair per cycle. No valid/ready handshake; pipeline always advances.
- Arithmetic:
  - Unsigned; no overflow possible, since the WIDTH+1-bit result holds the maximum 2*(2^WIDTH-1).
  - Result must equal in_a+in_b exactly for all inputs, including carry propagation across the split.
- Boundary cases:
  - Carry out of the low half (e.g. 0x00FF+0x0001) must reach the high half in stage 2.
  - All-ones operands give out_sum MSB = 1.
  - Reset asserted mid-stream discards in-flight results; out_sum goes to 0 immediately, without waiting for a clock.
  - After release, the first valid output appears 2 edges after the first sampled input.
- Inputs changing between edges have no effect; only edge-sampled values matter.
- No combinational path from inputs to out_sum.

Decomposition:
- Shared package: WIDTH default constant and derived LO_W/HI_W localparams. No typedefs needed.
- One natural sub-module, adder_buf_slice: a parameterised N-bit adder with carry-in and carry-out, purely combinational.
  - Instantiated once per stage: low half with cin=0; high half with cin=s1_c.
- Pipeline registers live in the top module.

Test Plan:
- Hold reset low for 3 edges with in_a=199, in_b=1 -> out_sum stays 0. Release, keep inputs -> out_sum=200 two edges after the first sampling edge.
- Back-to-back stream 199+1, 199+100, 1990+183 on consecutive cycles -> out_sum = 200, 299, 2173 on consecutive cycles, each 2 cycles after its input.
- Low-half carry: 0x00FF+0x0001 -> 0x0100; 0x80FF+0x7F01 -> 0x10000.
- Maximum: 0xFFFF+0xFFFF -> 0x1FFFE; 0xFFFF+0x0001 -> 0x10000; 0+0 -> 0.
- Reset mid-stream:
  - Stream values, assert reset between edges -> out_sum clears to 0 asynchronously.
  - After release, no stale pre-reset sums appear; first new result arrives at the correct latency.
- Random: 1000 random operand pairs at full rate, compared against a reference queue delayed 2 cycles -> zero mismatches.
